svm_win_sched: RTL and testbench

Scheduler that sequences the 36-feature SVM parallel element (PE) across every detection window of a HOG block map. For each window position it walks all blocks in raster order, issues feature-buffer and coefficient-ROM addresses, feeds the running sum back into the PE, adds the bias, and emits one classification result per window on a valid/ready port. It sits between the HOG block buffer / coefficient ROM and the detection output logic.

---
 rtl/svm_pkg.sv | 25 ++
 rtl/svm_win_cnt.sv | 91 +++++++++
 rtl/svm_win_sched.sv | 184 ++++++++++++++++++
 tb/tb_svm_win_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// svm_pkg: shared constants, state encoding and a width helper for the SVM window scheduler.
package svm_pkg;

    localparam int DEF_FEA_I  = 4;
    localparam int DEF_FEA_F  = 28;
    localparam int FEA_N      = DEF_FEA_I + DEF_FEA_F;

    localparam int DEF_IMG_BW = 39;
    localparam int DEF_IMG_BH = 29;
    localparam int DEF_WIN_BW = 7;
    localparam int DEF_WIN_BH = 15;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Counter/address width that never collapses to zero bits for degenerate geometries.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/svm_win_cnt.sv
// svm_win_cnt: nested block-within-window and window-origin counters, both raster order
// with the column fastest, plus last-block and last-window flags.
module svm_win_cnt
    import svm_pkg::*;
#(
    parameter int IMG_BW = DEF_IMG_BW,
    parameter int IMG_BH = DEF_IMG_BH,
    parameter int WIN_BW = DEF_WIN_BW,
    parameter int WIN_BH = DEF_WIN_BH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            blk_adv,
    input  logic                            win_adv,
    output logic [clog2_min1(WIN_BW)-1:0]   bx,
    output logic [clog2_min1(WIN_BH)-1:0]   by,
    output logic [clog2_min1(IMG_BW)-1:0]   wx,
    output logic [clog2_min1(IMG_BH)-1:0]   wy,
    output logic                            last_blk,
    output logic                            last_win
);
    localparam int BX_W = clog2_min1(WIN_BW);
    localparam int BY_W = clog2_min1(WIN_BH);
    localparam int WX_W = clog2_min1(IMG_BW);
    localparam int WY_W = clog2_min1(IMG_BH);

    logic [BX_W-1:0] bx_q, bx_d;
    logic [BY_W-1:0] by_q, by_d;
    logic [WX_W-1:0] wx_q, wx_d;
    logic [WY_W-1:0] wy_q, wy_d;
    logic last_bx, last_by, last_wx, last_wy;

    assign last_bx  = (bx_q == BX_W'(WIN_BW - 1));
    assign last_by  = (by_q == BY_W'(WIN_BH - 1));
    assign last_wx  = (wx_q == WX_W'(IMG_BW - WIN_BW));
    assign last_wy  = (wy_q == WY_W'(IMG_BH - WIN_BH));
    assign last_blk = last_bx && last_by;
    assign last_win = last_wx && last_wy;

    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        wx_d = wx_q;
        wy_d = wy_q;
        if (clear) begin
            bx_d = '0;
            by_d = '0;
            wx_d = '0;
            wy_d = '0;
        end else begin
            if (blk_adv) begin
                if (last_bx) begin
                    bx_d = '0;
                    by_d = last_by ? '0 : by_q + 1'b1;
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
            // Both counters wrap to zero so the scan ends back at the origin.
            if (win_adv) begin
                if (last_wx) begin
                    wx_d = '0;
                    wy_d = last_wy ? '0 : wy_q + 1'b1;
                end else begin
                    wx_d = wx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
            wx_q <= '0;
            wy_q <= '0;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            wx_q <= wx_d;
            wy_q <= wy_d;
        end
    end

    assign bx = bx_q;
    assign by = by_q;
    assign wx = wx_q;
    assign wy = wy_q;

endmodule

// File: rtl/svm_win_sched.sv
// svm_win_sched: drives the 36-feature SVM PE over every detection window of a HOG block map.
// Define SVM_SCORE_OUT_EN to expose the captured signed score on det_score.
module svm_win_sched
    import svm_pkg::*;
#(
    parameter int FEA_I  = DEF_FEA_I,
    parameter int FEA_F  = DEF_FEA_F,
    parameter int IMG_BW = DEF_IMG_BW,
    parameter int IMG_BH = DEF_IMG_BH,
    parameter int WIN_BW = DEF_WIN_BW,
    parameter int WIN_BH = DEF_WIN_BH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [FEA_I+FEA_F-1:0]                  bias,
    output logic                                    busy,
    output logic                                    done,
    output logic [clog2_min1(IMG_BW*IMG_BH)-1:0]    fea_addr,
    output logic [clog2_min1(WIN_BW*WIN_BH)-1:0]    coef_addr,
    output logic [FEA_I+FEA_F-1:0]                  pe_data,
    output logic                                    pe_valid,
    input  logic [FEA_I+FEA_F-1:0]                  pe_result,
    output logic                                    det_valid,
    input  logic                                    det_ready,
    output logic [clog2_min1(IMG_BW)-1:0]           det_x,
    output logic [clog2_min1(IMG_BH)-1:0]           det_y,
    output logic                                    det_hit
`ifdef SVM_SCORE_OUT_EN
    ,
    output logic [FEA_I+FEA_F-1:0]                  det_score
`endif
);
    localparam int DW   = FEA_I + FEA_F;
    localparam int FA_W = clog2_min1(IMG_BW * IMG_BH);
    localparam int CA_W = clog2_min1(WIN_BW * WIN_BH);
    localparam int X_W  = clog2_min1(IMG_BW);
    localparam int Y_W  = clog2_min1(IMG_BH);
    localparam int BX_W = clog2_min1(WIN_BW);
    localparam int BY_W = clog2_min1(WIN_BH);

    if (WIN_BW > IMG_BW || WIN_BH > IMG_BH) begin : g_bad_geometry
        $error("svm_win_sched: window (%0d x %0d) exceeds image (%0d x %0d)",
               WIN_BW, WIN_BH, IMG_BW, IMG_BH);
    end

    state_t          state_q, state_d;
    logic [DW-1:0]   bias_q, bias_d;
    logic            done_q, done_d;
    logic            pe_valid_q, pe_valid_d;
    logic            first_q, first_d;
    logic            drain_cap_q, drain_cap_d;
    logic            hit_q, hit_d;
    logic [DW-1:0]   score;
    logic            capture;
    logic            clear, blk_adv, win_adv, last_blk, last_win;
    logic [BX_W-1:0] bx;
    logic [BY_W-1:0] by;
    logic [X_W-1:0]  wx;
    logic [Y_W-1:0]  wy;

    svm_win_cnt #(
        .IMG_BW (IMG_BW),
        .IMG_BH (IMG_BH),
        .WIN_BW (WIN_BW),
        .WIN_BH (WIN_BH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .blk_adv  (blk_adv),
        .win_adv  (win_adv),
        .bx       (bx),
        .by       (by),
        .wx       (wx),
        .wy       (wy),
        .last_blk (last_blk),
        .last_win (last_win)
    );

    // DRAIN spans two cycles: the final MAC lands, then pe_result + bias is captured.
    assign score   = pe_result + bias_q;
    assign capture = (state_q == DRAIN) && drain_cap_q;

    always_comb begin
        state_d     = state_q;
        bias_d      = bias_q;
        done_d      = 1'b0;
        pe_valid_d  = 1'b0;
        first_d     = 1'b0;
        drain_cap_d = drain_cap_q;
        hit_d       = hit_q;
        clear       = 1'b0;
        blk_adv     = 1'b0;
        win_adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    clear   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_adv    = 1'b1;
                pe_valid_d = 1'b1;
                first_d    = (bx == '0) && (by == '0);
                if (last_blk) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_cap_q) begin
                    drain_cap_d = 1'b1;
                end else begin
                    drain_cap_d = 1'b0;
                    hit_d       = ~score[DW-1] & (|score);
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (det_ready) begin
                    win_adv = 1'b1;
                    if (last_win) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bias_q      <= '0;
            done_q      <= 1'b0;
            pe_valid_q  <= 1'b0;
            first_q     <= 1'b0;
            drain_cap_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bias_q      <= bias_d;
            done_q      <= done_d;
            pe_valid_q  <= pe_valid_d;
            first_q     <= first_d;
            drain_cap_q <= drain_cap_d;
            hit_q       <= hit_d;
        end
    end

`ifdef SVM_SCORE_OUT_EN
    logic [DW-1:0] score_q, score_d;

    assign score_d = capture ? score : score_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign det_score = score_q;
`endif

    // The PE output is registered, so the partial sum is fed back combinationally.
    assign pe_data   = (pe_valid_q && !first_q) ? pe_result : '0;
    assign pe_valid  = pe_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign det_valid = (state_q == OUT);
    assign det_x     = wx;
    assign det_y     = wy;
    assign det_hit   = hit_q;
    assign coef_addr = CA_W'(by) * CA_W'(WIN_BW) + CA_W'(bx);
    assign fea_addr  = (FA_W'(wy) + FA_W'(by)) * FA_W'(IMG_BW) + FA_W'(wx) + FA_W'(bx);

endmodule

// File: tb/tb_svm_win_sched.sv
// tb_svm_win_sched: directed bench for svm_win_sched with a behavioural PE, feature buffer and ROM.
// Features use Q8.24 so 72.0 is representable; dut_b traces addresses on a 4x3 image.
module tb_svm_win_sched;

    localparam logic [31:0] ONE = 32'h0100_0000;

    typedef struct {
        logic [31:0] bias;
        logic        exp_hit;
        logic [31:0] exp_score;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start_a = 1'b0;
    logic [31:0] bias_a = '0;
    logic        ready_a = 1'b1;
    logic        busy_a, done_a, pe_valid_a, det_valid_a, det_hit_a;
    logic [2:0]  fea_addr_a;
    logic [0:0]  coef_addr_a;
    logic [31:0] pe_data_a;
    logic [31:0] pe_result_a = '0;
    logic [1:0]  det_x_a;
    logic [0:0]  det_y_a;

    logic        start_b = 1'b0;
    logic [31:0] bias_b = '0;
    logic        ready_b = 1'b1;
    logic        busy_b, done_b, pe_valid_b, det_valid_b, det_hit_b;
    logic [3:0]  fea_addr_b;
    logic [1:0]  coef_addr_b;
    logic [31:0] pe_data_b;
    logic [31:0] pe_result_b = '0;
    logic [1:0]  det_x_b;
    logic [1:0]  det_y_b;

`ifdef SVM_SCORE_OUT_EN
    logic [31:0] det_score_a, det_score_b;
`endif

    logic [31:0] fea_mem [8];
    logic [31:0] coef_mem [2];
    logic [31:0] fea_rd = '0;
    logic [31:0] coef_rd = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    vec_t vecs [4];
    int trace_fea [4];

    always #5 clk = ~clk;

    svm_win_sched #(
        .FEA_I(8), .FEA_F(24), .IMG_BW(3), .IMG_BH(2), .WIN_BW(2), .WIN_BH(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bias(bias_a),
        .busy(busy_a), .done(done_a), .fea_addr(fea_addr_a), .coef_addr(coef_addr_a),
        .pe_data(pe_data_a), .pe_valid(pe_valid_a), .pe_result(pe_result_a),
        .det_valid(det_valid_a), .det_ready(ready_a), .det_x(det_x_a), .det_y(det_y_a),
        .det_hit(det_hit_a)
`ifdef SVM_SCORE_OUT_EN
        , .det_score(det_score_a)
`endif
    );

    svm_win_sched #(
        .FEA_I(8), .FEA_F(24), .IMG_BW(4), .IMG_BH(3), .WIN_BW(2), .WIN_BH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bias(bias_b),
        .busy(busy_b), .done(done_b), .fea_addr(fea_addr_b), .coef_addr(coef_addr_b),
        .pe_data(pe_data_b), .pe_valid(pe_valid_b), .pe_result(pe_result_b),
        .det_valid(det_valid_b), .det_ready(ready_b), .det_x(det_x_b), .det_y(det_y_b),
        .det_hit(det_hit_b)
`ifdef SVM_SCORE_OUT_EN
        , .det_score(det_score_b)
`endif
    );

    // One block of 36 identical features times one coefficient, Q8.24 product.
    function automatic logic [31:0] mac36(input logic [31:0] f, input logic [31:0] c);
        longint p;
        p = (longint'($signed(f)) * longint'($signed(c))) >>> 24;
        return 32'(p * 36);
    endfunction

    // Synchronous feature/coefficient reads feeding a registered PE.
    always @(posedge clk) begin
        fea_rd  <= fea_mem[fea_addr_a];
        coef_rd <= coef_mem[coef_addr_a];
        if (pe_valid_a) pe_result_a <= pe_data_a + mac36(fea_rd, coef_rd);
    end

    always @(negedge clk) begin
        if (done_a) done_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] b);
        @(negedge clk);
        bias_a  = b;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic runFrame(input logic [31:0] b, input logic eh, input logic [31:0] es, input bit poke);
        int cnt;
        int done0;
        done0   = done_cnt;
        ready_a = 1'b1;
        applyStimulus(b);
        checkOutput("busy_after_start", 32'(busy_a), 32'd1);
        for (int w = 0; w < 4; w++) begin
            checkOutput("first_fea_addr", 32'(fea_addr_a), 32'((w / 2) * 3 + (w % 2)));
            checkOutput("first_coef_addr", 32'(coef_addr_a), 32'd0);
            cnt = 0;
            if (poke) begin
                start_a = 1'b1;
                bias_a  = 32'hB000_0000;
                @(negedge clk);
                start_a = 1'b0;
                cnt = 1;
            end
            while (!det_valid_a && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("det_latency", 32'(cnt), 32'd4);
            checkOutput("det_x", 32'(det_x_a), 32'(w % 2));
            checkOutput("det_y", 32'(det_y_a), 32'(w / 2));
            checkOutput("det_hit", 32'(det_hit_a), 32'(eh));
`ifdef SVM_SCORE_OUT_EN
            checkOutput("det_score", det_score_a, es);
`else
            if (es === 32'hFFFF_FFFF) checkOutput("score_sentinel", 32'(det_hit_a), 32'd0);
`endif
            @(negedge clk);
            checkOutput("det_valid_after_accept", 32'(det_valid_a), 32'd0);
            checkOutput("done_timing", 32'(done_a), 32'(w == 3));
            checkOutput("busy_timing", 32'(busy_a), 32'(w != 3));
        end
        repeat (3) @(negedge clk);
        checkOutput("done_count", 32'(done_cnt - done0), 32'd1);
    endtask

    initial begin
        int cnt;
        int accepts;
        int seen;
        int done0;

        for (int i = 0; i < 8; i++) fea_mem[i] = ONE;
        coef_mem[0] = ONE;
        coef_mem[1] = ONE;
        trace_fea[0] = 5;
        trace_fea[1] = 6;
        trace_fea[2] = 9;
        trace_fea[3] = 10;

        vecs[0] = '{bias: 32'h0000_0000, exp_hit: 1'b1, exp_score: 32'h4800_0000};
        vecs[1] = '{bias: 32'hB000_0000, exp_hit: 1'b0, exp_score: 32'hF800_0000};
        vecs[2] = '{bias: 32'hB800_0000, exp_hit: 1'b0, exp_score: 32'h0000_0000};
        vecs[3] = '{bias: 32'hB900_0000, exp_hit: 1'b1, exp_score: 32'h0100_0000};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_pe_valid", 32'(pe_valid_a), 32'd0);
        checkOutput("rst_pe_data", pe_data_a, 32'd0);
        checkOutput("rst_addrs", 32'({fea_addr_a, coef_addr_a}), 32'd0);
        checkOutput("rst_det", 32'({det_valid_a, det_x_a, det_y_a, det_hit_a}), 32'd0);
        rst = 1'b0;

        $display("[TB] table-driven frames");
        for (int v = 0; v < 4; v++) begin
            runFrame(vecs[v].bias, vecs[v].exp_hit, vecs[v].exp_score, 1'b0);
        end

        $display("[TB] start pulsed while busy");
        runFrame(vecs[0].bias, vecs[0].exp_hit, vecs[0].exp_score, 1'b1);

        $display("[TB] det_ready stall");
        done0   = done_cnt;
        ready_a = 1'b0;
        applyStimulus(32'h0);
        cnt = 0;
        while (!det_valid_a && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("stall_latency", 32'(cnt), 32'd4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_hold", 32'({det_valid_a, pe_valid_a, busy_a, det_hit_a, det_x_a, det_y_a}),
                        32'({1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0}));
            if (i == 3) start_a = 1'b1;
            if (i == 4) start_a = 1'b0;
            @(negedge clk);
        end
        ready_a = 1'b1;
        @(negedge clk);
        checkOutput("release_fea_addr", 32'(fea_addr_a), 32'd1);
        checkOutput("release_coef_addr", 32'(coef_addr_a), 32'd0);
        checkOutput("release_det_valid", 32'(det_valid_a), 32'd0);
        @(negedge clk);
        checkOutput("release_pe_valid", 32'(pe_valid_a), 32'd1);
        checkOutput("release_pe_data", pe_data_a, 32'd0);
        cnt = 0;
        while (!done_a && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("stall_done_seen", 32'(done_a), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("stall_done_count", 32'(done_cnt - done0), 32'd1);

        $display("[TB] reset during window 2");
        done0   = done_cnt;
        ready_a = 1'b1;
        applyStimulus(32'h0);
        accepts = 0;
        cnt     = 0;
        while (accepts < 2 && cnt < 100) begin
            if (det_valid_a) accepts++;
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        checkOutput("mid_window_pos", 32'({det_x_a, det_y_a, fea_addr_a, coef_addr_a}),
                    32'({2'd0, 1'b1, 3'd4, 1'b1}));
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy_a), 32'd0);
        checkOutput("midrst_pe", 32'({pe_valid_a, pe_data_a}), 32'd0);
        checkOutput("midrst_addrs", 32'({fea_addr_a, coef_addr_a}), 32'd0);
        checkOutput("midrst_det", 32'({det_valid_a, det_x_a, det_y_a, det_hit_a, done_a}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_done", 32'(done_cnt - done0), 32'd0);
        runFrame(vecs[3].bias, vecs[3].exp_hit, vecs[3].exp_score, 1'b0);

        $display("[TB] address trace on 4x3 image");
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen = 0;
        cnt  = 0;
        while (seen < 4 && cnt < 200) begin
            if (det_valid_b) seen++;
            @(negedge clk);
            cnt++;
        end
        checkOutput("trace_window", 32'({det_x_b, det_y_b}), 32'({2'd1, 2'd1}));
        for (int k = 0; k < 4; k++) begin
            checkOutput("trace_fea_addr", 32'(fea_addr_b), 32'(trace_fea[k]));
            checkOutput("trace_coef_addr", 32'(coef_addr_b), 32'(k));
            @(negedge clk);
            checkOutput("trace_pe_valid", 32'(pe_valid_b), 32'd1);
        end
        cnt = 0;
        while (!done_b && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("trace_done_seen", 32'(done_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
